// File: rtl/udp_encoder.sv
// UDP segment builder: buffers the payload, sums pseudo-header + UDP header + payload
// into a wide accumulator, then streams {ports}, {length, checksum} and the payload words.
module udp_encoder #(
    parameter int MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] len_data,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_rdy,
    output logic [31:0] data,
    output logic        wr_en,
    output logic        fin,
    output logic        busy,
    output logic        err
);
    localparam int AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CW    = $clog2(MAX_WORDS + 1);
    localparam int ACC_W = 16 + $clog2(2 * MAX_WORDS + 16);
    localparam logic [16:0] MAX_BYTES = 17'(4 * MAX_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, FOLD, HDR0, HDR1, PAY} state_t;

    state_t           state_reg, state_next;
    logic [15:0]      src_port_reg, src_port_next;
    logic [15:0]      dest_port_reg, dest_port_next;
    logic [15:0]      len_udp_reg, len_udp_next;
    logic [15:0]      csum_reg, csum_next;
    logic [1:0]       tail_reg, tail_next;
    logic [CW-1:0]    words_reg, words_next;
    logic [CW-1:0]    wr_idx_reg, wr_idx_next;
    logic [CW-1:0]    rd_idx_reg, rd_idx_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [31:0]      data_reg, data_next;
    logic             wr_en_reg, wr_en_next;
    logic             fin_reg, fin_next;
    logic             err_reg, err_next;

    logic [31:0]      mem [MAX_WORDS];
    logic [31:0]      rd_data_reg;
    logic [AW-1:0]    rd_addr;
    logic             mem_we;

    logic [15:0]      len_udp_in;
    logic [ACC_W-1:0] hdr_sum;
    logic             last_word;
    logic [3:0]       byte_keep;
    logic [31:0]      pay_word;
    logic [16:0]      fold1;
    logic [15:0]      fold2;
    logic [15:0]      csum_raw;

    assign len_udp_in = len_data + 16'd8;
    assign hdr_sum = ACC_W'(src_ip[31:16]) + ACC_W'(src_ip[15:0])
                   + ACC_W'(dest_ip[31:16]) + ACC_W'(dest_ip[15:0])
                   + ACC_W'(16'h0011) + ACC_W'(len_udp_in) + ACC_W'(len_udp_in)
                   + ACC_W'(src_port) + ACC_W'(dest_port);

    // Bytes past the end of the payload are zeroed in the final word only.
    assign last_word = (wr_idx_reg + CW'(1)) == words_reg;
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad
        assign byte_keep[gi] = !last_word || (tail_reg == 2'd0) || (2'(gi) < tail_reg);
        assign pay_word[31-8*gi -: 8] = byte_keep[gi] ? data_in[31-8*gi -: 8] : 8'h00;
    end

    // Two end-around folds are enough: the first leaves at most a single carry.
    assign fold1    = {1'b0, acc_reg[15:0]} + 17'(acc_reg[ACC_W-1:16]);
    assign fold2    = fold1[15:0] + {15'd0, fold1[16]};
    assign csum_raw = ~fold2;

    // Read one word ahead so the registered read data is ready on each PAY edge.
    assign rd_addr = (state_reg == PAY) ? rd_idx_reg[AW-1:0] + AW'(1) : '0;

    always_comb begin
        state_next     = state_reg;
        src_port_next  = src_port_reg;
        dest_port_next = dest_port_reg;
        len_udp_next   = len_udp_reg;
        csum_next      = csum_reg;
        tail_next      = tail_reg;
        words_next     = words_reg;
        wr_idx_next    = wr_idx_reg;
        rd_idx_next    = rd_idx_reg;
        acc_next       = acc_reg;
        data_next      = data_reg;
        wr_en_next     = 1'b0;
        fin_next       = 1'b0;
        err_next       = 1'b0;
        mem_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !fin_reg) begin
                    if ({1'b0, len_data} > MAX_BYTES) begin
                        err_next = 1'b1;
                    end else begin
                        src_port_next  = src_port;
                        dest_port_next = dest_port;
                        len_udp_next   = len_udp_in;
                        tail_next      = len_data[1:0];
                        words_next     = CW'((len_data + 16'd3) >> 2);
                        wr_idx_next    = '0;
                        acc_next       = hdr_sum;
                        state_next     = (len_data == 16'd0) ? FOLD : LOAD;
                    end
                end
            end
            LOAD: begin
                if (data_valid) begin
                    mem_we      = 1'b1;
                    acc_next    = acc_reg + ACC_W'(pay_word[31:16]) + ACC_W'(pay_word[15:0]);
                    wr_idx_next = wr_idx_reg + CW'(1);
                    if (last_word) state_next = FOLD;
                end
            end
            FOLD: begin
                csum_next  = (csum_raw == 16'h0000) ? 16'hFFFF : csum_raw;
                acc_next   = '0;
                state_next = HDR0;
            end
            HDR0: begin
                wr_en_next = 1'b1;
                data_next  = {src_port_reg, dest_port_reg};
                state_next = HDR1;
            end
            HDR1: begin
                wr_en_next  = 1'b1;
                data_next   = {len_udp_reg, csum_reg};
                rd_idx_next = '0;
                if (words_reg == '0) begin
                    fin_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = PAY;
                end
            end
            PAY: begin
                wr_en_next  = 1'b1;
                data_next   = rd_data_reg;
                rd_idx_next = rd_idx_reg + CW'(1);
                if ((rd_idx_reg + CW'(1)) == words_reg) begin
                    fin_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            src_port_reg  <= '0;
            dest_port_reg <= '0;
            len_udp_reg   <= '0;
            csum_reg      <= '0;
            tail_reg      <= '0;
            words_reg     <= '0;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            acc_reg       <= '0;
            data_reg      <= '0;
            wr_en_reg     <= 1'b0;
            fin_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            src_port_reg  <= src_port_next;
            dest_port_reg <= dest_port_next;
            len_udp_reg   <= len_udp_next;
            csum_reg      <= csum_next;
            tail_reg      <= tail_next;
            words_reg     <= words_next;
            wr_idx_reg    <= wr_idx_next;
            rd_idx_reg    <= rd_idx_next;
            acc_reg       <= acc_next;
            data_reg      <= data_next;
            wr_en_reg     <= wr_en_next;
            fin_reg       <= fin_next;
            err_reg       <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx_reg[AW-1:0]] <= pay_word;
        rd_data_reg <= mem[rd_addr];
    end

    assign data_rdy = (state_reg == LOAD);
    assign busy     = (state_reg != IDLE) || fin_reg;
    assign data     = data_reg;
    assign wr_en    = wr_en_reg;
    assign fin      = fin_reg;
    assign err      = err_reg;
endmodule

// File: tb/tb_udp_encoder.sv
// Randomized self-checking bench for udp_encoder against a byte-level UDP reference model.
module tb_udp_encoder;
    localparam int MAX_WORDS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src_ip, dest_ip, data_in;
    logic [15:0] src_port, dest_port, len_data;
    logic        start, data_valid;
    logic        data_rdy, wr_en, fin, busy, err;
    logic [31:0] data;

    always #5 clk = ~clk;

    udp_encoder #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .src_ip(src_ip), .dest_ip(dest_ip),
        .src_port(src_port), .dest_port(dest_port), .len_data(len_data),
        .start(start), .data_in(data_in), .data_valid(data_valid),
        .data_rdy(data_rdy), .data(data), .wr_en(wr_en), .fin(fin),
        .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] pay_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        got_fin_q[$];
    logic        got_busy_q[$];
    int          got_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_q.push_back(data);
            got_fin_q.push_back(fin);
            got_busy_q.push_back(busy);
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: RFC 768 checksum over pseudo-header, header and zero-padded payload bytes.
    function automatic void build_expected(input logic [31:0] sip, input logic [31:0] dip,
                                           input logic [15:0] sp, input logic [15:0] dp,
                                           input logic [15:0] len);
        int          s;
        logic [15:0] lu;
        logic [15:0] c;
        logic [31:0] w;
        logic [31:0] padded[$];
        lu = len + 16'd8;
        s = sip[31:16] + sip[15:0] + dip[31:16] + dip[15:0] + 17 + 2 * lu + sp + dp;
        for (int i = 0; i < (int'(len) + 3) / 4; i++) begin
            w = pay_q[i];
            for (int b = 0; b < 4; b++)
                if (4 * i + b >= int'(len)) w[31-8*b -: 8] = 8'h00;
            padded.push_back(w);
            s = s + w[31:16] + w[15:0];
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        c = ~s[15:0];
        if (c == 16'h0000) c = 16'hFFFF;
        exp_q.delete();
        exp_q.push_back({sp, dp});
        exp_q.push_back({lu, c});
        foreach (padded[i]) exp_q.push_back(padded[i]);
    endfunction

    task automatic clear_capture();
        got_q.delete();
        got_fin_q.delete();
        got_busy_q.delete();
        got_cyc_q.delete();
    endtask

    // Drives one request and its payload; returns the edge number of the last store
    // (or of the start edge for an empty payload).
    task automatic send(input logic [31:0] sip, input logic [31:0] dip,
                        input logic [15:0] sp, input logic [15:0] dp,
                        input logic [15:0] len, input int max_stall, output int store_cyc);
        int nw;
        int st;
        nw = (int'(len) + 3) / 4;
        clear_capture();
        @(posedge clk); #1;
        src_ip = sip; dest_ip = dip; src_port = sp; dest_port = dp; len_data = len;
        start = 1'b1;
        store_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            repeat (st) begin @(posedge clk); #1; end
            data_in = pay_q[i];
            data_valid = 1'b1;
            n_checks++;
            if (data_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL data_rdy word %0d: got %b expected 1", i, data_rdy);
            end
            store_cyc = cyc + 1;
            @(posedge clk); #1;
            data_valid = 1'b0;
            data_in = $urandom;
        end
    endtask

    task automatic wait_fin(input int budget);
        int k;
        k = 0;
        while (!(got_fin_q.size() > 0 && got_fin_q[got_fin_q.size()-1] === 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL fin_timeout: got no fin within %0d cycles, expected fin", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({data, wr_en, fin, busy, err, data_rdy} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h wr_en=%b fin=%b busy=%b err=%b rdy=%b expected all 0",
                     data, wr_en, fin, busy, err, data_rdy);
        end
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_hello_world(input string tag);
        int store_cyc;
        pay_q = '{32'h48656c6c, 32'h6f20576f, 32'h726c64ab};
        exp_q = '{32'ha08f2694, 32'h00132560, 32'h48656c6c, 32'h6f20576f, 32'h726c6400};
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'd11, 0, store_cyc);
        wait_fin(100);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_fin_q[i] !== 1'(i == exp_q.size() - 1)
                || got_cyc_q[i] != store_cyc + 2 + i || got_busy_q[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s word %0d: got %h fin=%b cyc=%0d busy=%b expected %h fin=%b cyc=%0d busy=1",
                         tag, i, got_q[i], got_fin_q[i], got_cyc_q[i], got_busy_q[i],
                         exp_q[i], i == exp_q.size() - 1, store_cyc + 2 + i);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b expected 0", tag, busy);
        end
        $display("%s: len=11 words_out=%0d", tag, got_q.size());
    endtask

    task automatic test_zero_len();
        int store_cyc;
        pay_q.delete();
        build_expected(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'd0);
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'd0, 0, store_cyc);
        wait_fin(50);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL zero_len word_count: got %0d expected 2", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_fin_q[i] !== 1'(i == 1) || got_cyc_q[i] != store_cyc + 2 + i) begin
                n_fail++;
                $display("FAIL zero_len word %0d: got %h fin=%b cyc=%0d expected %h fin=%b cyc=%0d",
                         i, got_q[i], got_fin_q[i], got_cyc_q[i], exp_q[i], i == 1, store_cyc + 2 + i);
            end
        end
        $display("zero_len: checksum word %h", exp_q[1]);
    endtask

    task automatic test_datagram(input string tag, input logic [15:0] len, input int max_stall);
        int store_cyc;
        logic [31:0] sip, dip;
        logic [15:0] sp, dp;
        sip = $urandom; dip = $urandom; sp = 16'($urandom); dp = 16'($urandom);
        pay_q.delete();
        for (int i = 0; i < (int'(len) + 3) / 4; i++) pay_q.push_back($urandom);
        build_expected(sip, dip, sp, dp, len);
        send(sip, dip, sp, dp, len, max_stall, store_cyc);
        wait_fin(200);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_fin_q[i] !== 1'(i == exp_q.size() - 1)
                || got_cyc_q[i] != store_cyc + 2 + i) begin
                n_fail++;
                $display("FAIL %s word %0d: got %h fin=%b cyc=%0d expected %h fin=%b cyc=%0d",
                         tag, i, got_q[i], got_fin_q[i], got_cyc_q[i],
                         exp_q[i], i == exp_q.size() - 1, store_cyc + 2 + i);
            end
        end
        $display("%s: len=%0d words_out=%0d checksum=%h", tag, len, got_q.size(), exp_q[1][15:0]);
    endtask

    task automatic test_oversize();
        int err_cnt;
        int busy_cnt;
        clear_capture();
        @(posedge clk); #1;
        len_data = 16'(4 * MAX_WORDS + 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize err_pulse: got %b expected 1", err);
        end
        err_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (err === 1'b1) err_cnt++;
            if (busy !== 1'b0 || data_rdy !== 1'b0) busy_cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (err_cnt != 1 || busy_cnt != 0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL oversize: got err_cycles=%0d busy_cycles=%0d words=%0d expected 1/0/0",
                     err_cnt, busy_cnt, got_q.size());
        end
        $display("oversize: len=%0d rejected", 4 * MAX_WORDS + 1);
    endtask

    task automatic test_start_during_pay();
        int store_cyc;
        int k;
        pay_q.delete();
        for (int i = 0; i < 5; i++) pay_q.push_back($urandom);
        build_expected(32'h0a000001, 32'h0a000002, 16'h1234, 16'h5678, 16'd20);
        send(32'h0a000001, 32'h0a000002, 16'h1234, 16'h5678, 16'd20, 1, store_cyc);
        k = 0;
        while (got_q.size() < 3 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        src_port = 16'hdead; dest_port = 16'hbeef; len_data = 16'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_fin(100);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL pay_start word_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_fin_q[i] !== 1'(i == exp_q.size() - 1)) begin
                n_fail++;
                $display("FAIL pay_start word %0d: got %h fin=%b expected %h fin=%b",
                         i, got_q[i], got_fin_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pay_start busy_after: got %b expected 0", busy);
        end
        $display("pay_start: ignored request, words_out=%0d", got_q.size());
        test_datagram("after_pay_start", 16'd7, 0);
    endtask

    task automatic test_reset_mid_load();
        clear_capture();
        @(posedge clk); #1;
        src_ip = 32'h9801331b; dest_ip = 32'h980e5e4b;
        src_port = 16'ha08f; dest_port = 16'h2694; len_data = 16'd11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in = $urandom;
            data_valid = 1'b1;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({data, wr_en, fin, busy, err, data_rdy} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid_load outputs: got data=%h wr_en=%b fin=%b busy=%b err=%b rdy=%b expected all 0",
                     data, wr_en, fin, busy, err, data_rdy);
        end
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load discard: got words=%0d busy=%b expected 0/0", got_q.size(), busy);
        end
        $display("reset_mid_load: partial datagram discarded");
        test_hello_world("hello_after_reset");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = '0;
        src_ip = '0; dest_ip = '0; src_port = '0; dest_port = '0; len_data = '0;
        test_reset();
        test_hello_world("hello_world");
        test_zero_len();
        test_datagram("max_len_gaps", 16'(4 * MAX_WORDS), 3);
        test_oversize();
        test_start_during_pay();
        test_reset_mid_load();
        for (int t = 0; t < 6; t++)
            test_datagram("random", 16'($urandom_range(4 * MAX_WORDS, 0)), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
